// File: rtl/nios2_mul_shift_pipe.sv
// Two-stage multiply/shift pipeline: stage M holds operands and multiplier
// partial products, stage A holds the final result, each with its own valid.
module nios2_mul_shift_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_illegal
);

  localparam int unsigned SHAMT_W = $clog2(DATA_W);
  localparam int unsigned H       = DATA_W / 2;
  localparam int unsigned PP_W    = DATA_W + 2;
  localparam int unsigned P_W     = 2 * DATA_W;

  typedef enum logic [3:0] {
    OP_MUL    = 4'd0,
    OP_MULH   = 4'd1,
    OP_MULHSU = 4'd2,
    OP_MULHU  = 4'd3,
    OP_SLL    = 4'd4,
    OP_SRL    = 4'd5,
    OP_SRA    = 4'd6,
    OP_ROL    = 4'd7,
    OP_ROR    = 4'd8
  } op_e;

  logic               m_adv;
  logic               accept;

  logic               sgn1, sgn2;
  logic [DATA_W:0]    a_ext, b_ext;
  logic [PP_W-1:0]    a_lo, a_hi, b_lo, b_hi;
  logic [PP_W-1:0]    pp_ll_c, pp_lh_c, pp_hl_c, pp_hh_c;

  logic               m_valid_q, m_valid_d;
  logic [3:0]         m_op_q, m_op_d;
  logic [DATA_W-1:0]  m_src1_q, m_src1_d;
  logic [SHAMT_W-1:0] m_shamt_q, m_shamt_d;
  logic [TAG_W-1:0]   m_tag_q, m_tag_d;
  logic [PP_W-1:0]    m_pp_ll_q, m_pp_ll_d;
  logic [PP_W-1:0]    m_pp_lh_q, m_pp_lh_d;
  logic [PP_W-1:0]    m_pp_hl_q, m_pp_hl_d;
  logic [PP_W-1:0]    m_pp_hh_q, m_pp_hh_d;

  logic [P_W-1:0]     ll, lh, hl, hh, prod;
  logic [SHAMT_W:0]   inv_amt;
  logic [DATA_W-1:0]  sra_r, rol_r, ror_r;
  logic [DATA_W-1:0]  res_c;
  logic               ill_c;

  logic               a_valid_q, a_valid_d;
  logic [DATA_W-1:0]  a_result_q, a_result_d;
  logic [TAG_W-1:0]   a_tag_q, a_tag_d;
  logic               a_illegal_q, a_illegal_d;

  // Operands are sign/zero-extended to DATA_W+1 bits and split into a
  // zero-extended low half and a signed high half; four narrow products
  // are registered in M and recombined in A.
  always_comb begin
    sgn1    = (in_op == OP_MULH) || (in_op == OP_MULHSU);
    sgn2    = (in_op == OP_MULH);
    a_ext   = {sgn1 & in_src1[DATA_W-1], in_src1};
    b_ext   = {sgn2 & in_src2[DATA_W-1], in_src2};
    a_lo    = {{(PP_W-H){1'b0}}, a_ext[H-1:0]};
    a_hi    = {{(H+1){a_ext[DATA_W]}}, a_ext[DATA_W:H]};
    b_lo    = {{(PP_W-H){1'b0}}, b_ext[H-1:0]};
    b_hi    = {{(H+1){b_ext[DATA_W]}}, b_ext[DATA_W:H]};
    pp_ll_c = a_lo * b_lo;
    pp_lh_c = a_lo * b_hi;
    pp_hl_c = a_hi * b_lo;
    pp_hh_c = a_hi * b_hi;
  end

  always_comb begin
    ll      = {{(P_W-PP_W){m_pp_ll_q[PP_W-1]}}, m_pp_ll_q};
    lh      = {{(P_W-PP_W){m_pp_lh_q[PP_W-1]}}, m_pp_lh_q};
    hl      = {{(P_W-PP_W){m_pp_hl_q[PP_W-1]}}, m_pp_hl_q};
    hh      = {{(P_W-PP_W){m_pp_hh_q[PP_W-1]}}, m_pp_hh_q};
    prod    = ll + ((lh + hl) << H) + (hh << DATA_W);
    inv_amt = (SHAMT_W+1)'(DATA_W) - {1'b0, m_shamt_q};
    sra_r   = $signed(m_src1_q) >>> m_shamt_q;
    rol_r   = (m_src1_q << m_shamt_q) | (m_src1_q >> inv_amt);
    ror_r   = (m_src1_q >> m_shamt_q) | (m_src1_q << inv_amt);
    res_c   = '0;
    ill_c   = 1'b0;
    case (m_op_q)
      OP_MUL:    res_c = prod[DATA_W-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  res_c = prod[P_W-1:DATA_W];
      OP_SLL:    res_c = m_src1_q << m_shamt_q;
      OP_SRL:    res_c = m_src1_q >> m_shamt_q;
      OP_SRA:    res_c = sra_r;
      OP_ROL:    res_c = rol_r;
      OP_ROR:    res_c = ror_r;
      default:   ill_c = 1'b1;
    endcase
  end

  always_comb begin
    m_adv     = m_valid_q && (!a_valid_q || out_ready);
    in_ready  = !reset && !flush && (!m_valid_q || m_adv);
    accept    = in_valid && in_ready;

    m_op_d    = m_op_q;
    m_src1_d  = m_src1_q;
    m_shamt_d = m_shamt_q;
    m_tag_d   = m_tag_q;
    m_pp_ll_d = m_pp_ll_q;
    m_pp_lh_d = m_pp_lh_q;
    m_pp_hl_d = m_pp_hl_q;
    m_pp_hh_d = m_pp_hh_q;
    if (accept) begin
      m_op_d    = in_op;
      m_src1_d  = in_src1;
      m_shamt_d = in_src2[SHAMT_W-1:0];
      m_tag_d   = in_tag;
      m_pp_ll_d = pp_ll_c;
      m_pp_lh_d = pp_lh_c;
      m_pp_hl_d = pp_hl_c;
      m_pp_hh_d = pp_hh_c;
    end

    if (flush)       m_valid_d = 1'b0;
    else if (accept) m_valid_d = 1'b1;
    else if (m_adv)  m_valid_d = 1'b0;
    else             m_valid_d = m_valid_q;

    a_result_d  = a_result_q;
    a_tag_d     = a_tag_q;
    a_illegal_d = a_illegal_q;
    if (m_adv) begin
      a_result_d  = res_c;
      a_tag_d     = m_tag_q;
      a_illegal_d = ill_c;
    end

    if (flush)          a_valid_d = 1'b0;
    else if (m_adv)     a_valid_d = 1'b1;
    else if (out_ready) a_valid_d = 1'b0;
    else                a_valid_d = a_valid_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_q   <= 1'b0;
      m_op_q      <= '0;
      m_src1_q    <= '0;
      m_shamt_q   <= '0;
      m_tag_q     <= '0;
      m_pp_ll_q   <= '0;
      m_pp_lh_q   <= '0;
      m_pp_hl_q   <= '0;
      m_pp_hh_q   <= '0;
      a_valid_q   <= 1'b0;
      a_result_q  <= '0;
      a_tag_q     <= '0;
      a_illegal_q <= 1'b0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_op_q      <= m_op_d;
      m_src1_q    <= m_src1_d;
      m_shamt_q   <= m_shamt_d;
      m_tag_q     <= m_tag_d;
      m_pp_ll_q   <= m_pp_ll_d;
      m_pp_lh_q   <= m_pp_lh_d;
      m_pp_hl_q   <= m_pp_hl_d;
      m_pp_hh_q   <= m_pp_hh_d;
      a_valid_q   <= a_valid_d;
      a_result_q  <= a_result_d;
      a_tag_q     <= a_tag_d;
      a_illegal_q <= a_illegal_d;
    end
  end

  assign out_valid   = a_valid_q;
  assign out_result  = a_result_q;
  assign out_tag     = a_tag_q;
  assign out_illegal = a_illegal_q;

endmodule

// File: tb/tb_nios2_mul_shift_pipe.sv
// Bench for nios2_mul_shift_pipe: arithmetic reference model with an
// in-flight queue checked every cycle, plus directed literal vectors.
module tb_nios2_mul_shift_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 5;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [3:0]    in_op;
  logic [W-1:0]  in_src1, in_src2, out_result;
  logic [TW-1:0] in_tag, out_tag;

  nios2_mul_shift_pipe #(.DATA_W(W), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    logic          ill;
    int unsigned   cyc;
  } exp_t;

  exp_t          q[$];
  int unsigned   cyc = 0;
  int            tests = 0;
  int            fails = 0;
  logic          hold_v = 1'b0;
  logic [W-1:0]  hold_res;
  logic [TW-1:0] hold_tag;
  logic          hold_ill;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 2W-bit arithmetic and bit-by-bit shifting.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic ill);
    logic [2*W-1:0] p;
    logic [W-1:0]   x;
    int unsigned    s;
    s   = b % W;
    x   = a;
    r   = '0;
    ill = 1'b0;
    case (op)
      4'd0: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; end
      4'd1: begin p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b}; r = p[2*W-1:W]; end
      4'd2: begin p = {{W{a[W-1]}}, a} * {{W{1'b0}}, b}; r = p[2*W-1:W]; end
      4'd3: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[2*W-1:W]; end
      4'd4: for (int i = 0; i < s; i++) x = {x[W-2:0], 1'b0};
      4'd5: for (int i = 0; i < s; i++) x = {1'b0, x[W-1:1]};
      4'd6: for (int i = 0; i < s; i++) x = {x[W-1], x[W-1:1]};
      4'd7: for (int i = 0; i < s; i++) x = {x[W-2:0], x[W-1]};
      4'd8: for (int i = 0; i < s; i++) x = {x[0], x[W-1:1]};
      default: ill = 1'b1;
    endcase
    if (op >= 4'd4 && op <= 4'd8) r = x;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the in-flight queue.
  always @(negedge clk) begin
    exp_t e;
    logic exp_ov;
    if (reset) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_out_illegal", out_illegal, 0);
      chk("rst_in_ready", in_ready, 0);
      q.delete();
      hold_v = 1'b0;
    end else begin
      chk("in_ready", in_ready, (!flush && (q.size() < 2 || out_ready)) ? 1 : 0);
      exp_ov = (q.size() > 0) && (cyc >= q[0].cyc + 2);
      chk("out_valid", out_valid, exp_ov);
      if (hold_v && out_valid) begin
        chk("hold_result", out_result, hold_res);
        chk("hold_tag", out_tag, hold_tag);
        chk("hold_illegal", out_illegal, hold_ill);
      end
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("result", out_result, e.res);
        chk("tag", out_tag, e.tag);
        chk("illegal", out_illegal, e.ill);
      end
      if (in_valid && in_ready && !flush) begin
        model(in_op, in_src1, in_src2, e.res, e.ill);
        e.tag = in_tag;
        e.cyc = cyc;
        q.push_back(e);
      end
      hold_v   = out_valid && !out_ready && !flush;
      hold_res = out_result;
      hold_tag = out_tag;
      hold_ill = out_illegal;
      if (flush) q.delete();
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [TW-1:0] tag);
    logic acc;
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic directed(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [TW-1:0] tag,
                          input logic [W-1:0] er, input logic eill);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, "_early"}, out_valid, 0);
    @(posedge clk); #1;
    chk({name, "_valid"}, out_valid, 1);
    chk(name, out_result, er);
    chk({name, "_tag"}, out_tag, tag);
    chk({name, "_ill"}, out_illegal, eill);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit done;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_src1 = '0; in_src2 = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    directed("mul_ff",    4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001, 1'b0);
    directed("mulh_ff",   4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 1'b0);
    directed("mulhsu_ff", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 1'b0);
    directed("mulhu_ff",  4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 1'b0);
    directed("mul_small", 4'd0, 32'h0001_2345, 32'h0000_0010, 5'd5, 32'h0012_3450, 1'b0);
    directed("mulh_min",  4'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 1'b0);
    directed("sra_24",    4'd6, 32'h8000_0000, 32'h0000_0024, 5'd7, 32'hF800_0000, 1'b0);
    directed("srl_24",    4'd5, 32'h8000_0000, 32'h0000_0024, 5'd8, 32'h0800_0000, 1'b0);
    directed("ror_1",     4'd8, 32'h0000_0001, 32'h0000_0001, 5'd9, 32'h8000_0000, 1'b0);
    directed("rol_1",     4'd7, 32'h8000_0000, 32'h0000_0001, 5'd10, 32'h0000_0001, 1'b0);
    directed("sll_0",     4'd4, 32'h1234_5678, 32'h0000_0000, 5'd11, 32'h1234_5678, 1'b0);
    directed("sll_31",    4'd4, 32'h0000_0001, 32'h0000_001F, 5'd12, 32'h8000_0000, 1'b0);
    directed("rol_8",     4'd7, 32'h1234_5678, 32'hFFFF_FF08, 5'd13, 32'h3456_7812, 1'b0);
    directed("illegal12", 4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 32'h0000_0000, 1'b1);

    // Backpressure: three back-to-back ops with out_ready low for four cycles.
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        send(4'd0, 32'd3, 32'd5, 5'd1);
        send(4'd4, 32'd1, 32'd4, 5'd2);
        send(4'd3, 32'd7, 32'd9, 5'd3);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_tag_hold", out_tag, 1);
        chk("bp_result_hold", out_result, 15);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Flush with two ops in flight; an op offered during flush is dropped.
    out_ready = 1'b0;
    send(4'd0, 32'd11, 32'd13, 5'd20);
    send(4'd5, 32'hF0, 32'd4, 5'd21);
    flush = 1'b1; in_valid = 1'b1; in_op = 4'd0; in_src1 = 32'd2; in_src2 = 32'd2; in_tag = 5'd22;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    send(4'd0, 32'd6, 32'd7, 5'd25);
    send(4'd0, 32'd8, 32'd9, 5'd26);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_result", out_result, 0);
    chk("arst_out_tag", out_tag, 0);
    chk("arst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("arst_ready_release", in_ready, 1);
    @(posedge clk); #1;

    // Random ops with random backpressure.
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 1500; n++) begin
          send(4'($urandom_range(0, 15)), pick(), pick(), TW'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
